matrix_input_loader: RTL

//  Board-side writer for the systolic-array datapath: the operator enters two 2x2 8-bit operand matrices from switches and buttons.

---
 rtl/matrix_input_loader_pkg.sv | 35 +++
 rtl/matrix_input_loader_button_debouncer.sv | 56 +++++
 rtl/matrix_input_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/matrix_input_loader_pkg.sv
// ============================================================================
// matrix_input_loader_pkg
// Shared slot indices, operand width and FSM encoding for the operand loader.
// Rev 1.0
// ============================================================================
`default_nettype none

package matrix_input_loader_pkg;

  localparam int OPERAND_W  = 8;
  localparam int SLOT_COUNT = 8;
  localparam int INDEX_W    = 3;

  localparam logic [INDEX_W-1:0] SLOT_A11 = 3'd0;
  localparam logic [INDEX_W-1:0] SLOT_A12 = 3'd1;
  localparam logic [INDEX_W-1:0] SLOT_A21 = 3'd2;
  localparam logic [INDEX_W-1:0] SLOT_A22 = 3'd3;
  localparam logic [INDEX_W-1:0] SLOT_B11 = 3'd4;
  localparam logic [INDEX_W-1:0] SLOT_B12 = 3'd5;
  localparam logic [INDEX_W-1:0] SLOT_B21 = 3'd6;
  localparam logic [INDEX_W-1:0] SLOT_B22 = 3'd7;

  typedef enum logic [0:0] {
    ST_EDIT = 1'b0,
    ST_RUN  = 1'b1
  } loader_state_t;

  // Eight slots fill the index width exactly, so 7 -> 0 falls out of the add.
  function automatic logic [INDEX_W-1:0] next_index(input logic [INDEX_W-1:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_input_loader_button_debouncer.sv
// ============================================================================
// button_debouncer
// 2-FF synchroniser, stability counter and one-cycle press pulse on 0->1.
// Rev 1.0
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      r_press    <= r_stable & ~r_stable_q;
      // Any return to the stable level restarts the count, rejecting glitches.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/matrix_input_loader.sv
// ============================================================================
// matrix_input_loader
// Button/switch operand entry for the 2x2 systolic array: edit slots, launch, hold.
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_input_loader
  import matrix_input_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_next,
  input  logic                 btn_load,
  input  logic                 btn_start,
  input  logic                 sa_done,
  output logic [OPERAND_W-1:0] a11,
  output logic [OPERAND_W-1:0] a12,
  output logic [OPERAND_W-1:0] a21,
  output logic [OPERAND_W-1:0] a22,
  output logic [OPERAND_W-1:0] b11,
  output logic [OPERAND_W-1:0] b12,
  output logic [OPERAND_W-1:0] b21,
  output logic [OPERAND_W-1:0] b22,
  output logic                 start,
  output logic                 busy,
  output logic [INDEX_W-1:0]   cur_index,
  output logic [OPERAND_W-1:0] cur_value
);

  logic w_press_next;
  logic w_press_load;
  logic w_press_start;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
    .clk(clock_100Mhz), .rst_n(reset), .btn_raw(btn_next), .press(w_press_next)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load (
    .clk(clock_100Mhz), .rst_n(reset), .btn_raw(btn_load), .press(w_press_load)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
    .clk(clock_100Mhz), .rst_n(reset), .btn_raw(btn_start), .press(w_press_start)
  );

  logic [OPERAND_W-1:0] r_sw_meta;
  logic [OPERAND_W-1:0] r_sw_sync;
  logic [OPERAND_W-1:0] r_slot [SLOT_COUNT];
  logic [INDEX_W-1:0]   r_index;
  logic                 r_start;
  loader_state_t        r_state;
  loader_state_t        w_state_next;
  logic                 w_write;
  logic                 w_advance;
  logic                 w_launch;
  logic                 w_finish;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) r_state <= ST_EDIT;
    else        r_state <= w_state_next;
  end

  // Start has priority over editing; a done coincident with start is too early.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_advance    = 1'b0;
    w_launch     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_EDIT: begin
        if (w_press_start) begin
          w_launch     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_write   = w_press_load;
          w_advance = w_press_next;
        end
      end
      ST_RUN: begin
        if (sa_done && !r_start) begin
          w_finish     = 1'b1;
          w_state_next = ST_EDIT;
        end
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_index   <= '0;
      r_start   <= 1'b0;
      for (int i = 0; i < SLOT_COUNT; i++) r_slot[i] <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_start   <= w_launch;
      if (w_write) r_slot[r_index] <= r_sw_sync;
      if (w_finish)       r_index <= '0;
      else if (w_advance) r_index <= next_index(r_index);
    end
  end

  assign a11       = r_slot[SLOT_A11];
  assign a12       = r_slot[SLOT_A12];
  assign a21       = r_slot[SLOT_A21];
  assign a22       = r_slot[SLOT_A22];
  assign b11       = r_slot[SLOT_B11];
  assign b12       = r_slot[SLOT_B12];
  assign b21       = r_slot[SLOT_B21];
  assign b22       = r_slot[SLOT_B22];
  assign start     = r_start;
  assign busy      = (r_state == ST_RUN);
  assign cur_index = r_index;
  assign cur_value = r_slot[r_index];

endmodule

`default_nettype wire
